pc_call_stack: RTL and testbench
================================

# pc_call_stack

Program-counter and hardware return-stack unit that consumes the per-cycle sequencing controls produced by the control unit (`pc_en`, `mux_pc_branch`, `call`, `ret`) and produces the next instruction address. It sits between the control unit and instruction memory and holds the only copy of subroutine return addresses. Every instruction occupies one cycle. All state changes happen on the clock edge at which the controls are presented.

## Interface
- `ADDR_W`, 10: program-counter and target width in bits.
- `DEPTH`, 8: return-stack entries (power of two, ≥2).
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_en`  in  1  advance enable; low freezes PC and stack.
- `mux_pc_branch`  in  1  take non-sequential path this cycle.
- `call`  in  1  push return address (qualified by `mux_pc_branch`).
- `ret`  in  1  pop return address (qualified by `mux_pc_branch`).
- `target`  in  ADDR_W  branch/call destination from instruction field.
- `pc`  out  ADDR_W  current instruction address (registered).
- `depth`  out  $clog2(DEPTH)+1  occupied stack entries (registered).
- `stack_top`  out  ADDR_W  top-of-stack value; 0 when empty.
- `overflow`  out  1  sticky: call attempted with stack full.
- `underflow`  out  1  sticky: ret attempted with stack empty.

## Operation
Per clock edge with `rst`=0, `pc_en`=1, first matching rule wins:
- RET (`ret` & `mux_pc_branch`): depth>0 → `pc`←top, depth−1. Depth=0 → `pc`←`pc`+1, `underflow`←1, depth unchanged.
- CALL (`call` & `mux_pc_branch`): `pc`←`target` always. Depth<DEPTH → push `pc`+1, depth+1. Depth=DEPTH → push discarded, depth unchanged, `overflow`←1.
- JUMP (`mux_pc_branch` only): `pc`←`target`, stack unchanged.
- SEQ (otherwise): `pc`←`pc`+1.
- `call`/`ret` with `mux_pc_branch`=0 → SEQ, no stack activity. `call`&`ret` together → RET (ret precedence).
- `pc_en`=0: PC, stack, depth, and flags hold. Controls are ignored.
- Arithmetic: `pc`+1 is modulo 2^ADDR_W. At `pc`=2^ADDR_W−1, SEQ gives 0 and CALL pushes 0.
- Flags are sticky and clear only on reset.
- Reset: `pc`=RESET_PC, depth=0, `stack_top`=0, `overflow`=0, `underflow`=0. Stack contents are don't-care. Reset mid-subroutine discards all return addresses.

## Timing
- Single-cycle: controls and `target` sampled at edge N; `pc`, `depth`, and flags valid after edge N.
- `stack_top` is combinational from stack storage and depth. It reflects a push or pop in the cycle after the edge.
- Back-to-back CALL/RET every cycle is supported with no bubbles.
- A CALL immediately followed by RET returns to call-site+1 on the second edge.
- `rst` has priority over `pc_en`.

## Structure
- Shared package `cpu_pkg`: `ADDR_W` default constant, `pc_t` typedef (`logic [ADDR_W-1:0]`), and an enum `pc_op_e` {SEQ, JUMP, CALL, RET} used by the next-PC decode.
- Sub-module `return_stack`: LIFO of DEPTH×ADDR_W.
  - Inputs: push, pop, wdata. Outputs: top, depth, full, empty.
  - Stack pointer register; no reset on the storage array.
- Top level contains the op decode, next-PC mux, PC register, and sticky flags.

## Test plan
- Reset then 4 SEQ cycles → `pc` 0,1,2,3,4. `depth`=0, flags 0.
- At `pc`=5: JUMP `target`=0x120 → `pc`=0x120. Next SEQ → 0x121. `depth`=0.
- At `pc`=0x010: CALL `target`=0x200 → `pc`=0x200, `depth`=1, `stack_top`=0x011. Two SEQ cycles → 0x202. RET → `pc`=0x011, `depth`=0.
- 8 nested CALLs fill the stack (`depth`=8). A 9th CALL `target`=0x300 → `pc`=0x300, `depth`=8, `overflow`=1. 8 RETs unwind in LIFO order → `depth`=0. Another RET → `pc` increments, `underflow`=1.
- `pc`=0x3FF, CALL `target`=0x050 → `stack_top`=0x000. SEQ at 0x3FF in a separate run → 0x000.
- `pc_en`=0 with CALL asserted for 3 cycles → `pc`, `depth`, and flags unchanged. Assert `rst` mid-subroutine (`depth`=3) → `pc`=RESET_PC, `depth`=0, flags 0 after one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared PC width, PC type and next-PC operation decode.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W = 10;

  typedef logic [ADDR_W-1:0] pc_t;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    JUMP = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } pc_op_e;

  // call/ret only act on the non-sequential path; ret wins when both are set
  function automatic pc_op_e decode_op(input logic br, input logic call, input logic ret);
    pc_op_e op;
    op = SEQ;
    if (br && ret)       op = RET;
    else if (br && call) op = CALL;
    else if (br)         op = JUMP;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_call_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack_if
// Purpose  : Sequencing controls in, PC and return-stack status out.
// Revision : 1.0
// ============================================================================
interface pc_call_stack_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8
);
  logic                     pc_en;
  logic                     mux_pc_branch;
  logic                     call;
  logic                     ret;
  logic [ADDR_W-1:0]        target;
  logic [ADDR_W-1:0]        pc;
  logic [$clog2(DEPTH):0]   depth;
  logic [ADDR_W-1:0]        stack_top;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output pc_en, mux_pc_branch, call, ret, target,
    input  pc, depth, stack_top, overflow, underflow
  );

  modport slave (
    input  pc_en, mux_pc_branch, call, ret, target,
    output pc, depth, stack_top, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_stack
// Purpose  : DEPTH x ADDR_W LIFO of return addresses; pointer reset only.
// Revision : 1.0
// ============================================================================
module return_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [ADDR_W-1:0]      wdata,
  output logic      [ADDR_W-1:0]      top,
  output logic      [$clog2(DEPTH):0] depth,
  output logic                        full,
  output logic                        empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_sp;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_sp == (PTR_W+1)'(DEPTH));
  assign empty     = (r_sp == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop && !full;
  assign w_top_idx = r_sp[PTR_W-1:0] - 1'b1;
  assign top       = empty ? '0 : r_mem[w_top_idx];
  assign depth     = r_sp;

  always_ff @(posedge clk) begin
    if (rst)            r_sp <= '0;
    else if (w_do_pop)  r_sp <= r_sp - 1'b1;
    else if (w_do_push) r_sp <= r_sp + 1'b1;
  end

  // storage needs no reset: entries above the pointer are never observed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_sp[PTR_W-1:0]] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack
// Purpose  : Program counter with hardware return stack and sticky flags.
// Revision : 1.0
// ============================================================================
module pc_call_stack
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input wire logic          clk,
  input wire logic          rst,
  pc_call_stack_if.slave    bus
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_overflow;
  logic              r_underflow;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  pc_op_e            w_op;

  assign w_op     = decode_op(bus.mux_pc_branch, bus.call, bus.ret);
  assign w_pc_inc = r_pc + 1'b1;
  assign w_push   = bus.pc_en && (w_op == CALL);
  assign w_pop    = bus.pc_en && (w_op == RET);

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_pc_inc),
    .top   (w_top),
    .depth (bus.depth),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_pc_nxt = w_pc_inc;
    unique case (w_op)
      RET:     w_pc_nxt = w_empty ? w_pc_inc : w_top;
      CALL:    w_pc_nxt = bus.target;
      JUMP:    w_pc_nxt = bus.target;
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.pc_en) begin
      r_pc <= w_pc_nxt;
      if (w_op == CALL && w_full)  r_overflow  <= 1'b1;
      if (w_op == RET  && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.stack_top = w_top;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_call_stack
// Purpose  : Vector table plus hand sequences, checked through a queue.
// Revision : 1.0
// ============================================================================
module tb_pc_call_stack;
  import cpu_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       br;
    logic       call;
    logic       ret;
    pc_t        tgt;
    pc_t        pc;
    logic [3:0] dep;
    pc_t        top;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  vec_t tbl[18];

  pc_call_stack_if #(.ADDR_W(10), .DEPTH(8)) bus ();

  pc_call_stack #(.ADDR_W(10), .DEPTH(8), .RESET_PC(10'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic en, logic br, logic call, logic ret,
                              pc_t tgt, pc_t pc, logic [3:0] dep, pc_t top, logic ovf, logic unf);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.br = br; v.call = call; v.ret = ret;
    v.tgt = tgt; v.pc = pc; v.dep = dep; v.top = top; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check_one();
    vec_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    if (bus.pc !== e.pc || bus.depth !== e.dep || bus.stack_top !== e.top ||
        bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
      n_fail++;
      $display("FAIL %s: got pc=%h depth=%0d top=%h ovf=%b unf=%b, required pc=%h depth=%0d top=%h ovf=%b unf=%b",
               e.name, bus.pc, bus.depth, bus.stack_top, bus.overflow, bus.underflow,
               e.pc, e.dep, e.top, e.ovf, e.unf);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; bus.pc_en = v.en; bus.mux_pc_branch = v.br;
    bus.call = v.call; bus.ret = v.ret; bus.target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    pc_t        ret_q[8];
    pc_t        e_pc;
    logic [3:0] e_dep;

    rst = 1'b1; bus.pc_en = 1'b0; bus.mux_pc_branch = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.target = '0;

    tbl[0]  = mk("seq1",      0,1,0,0,0, 10'h000, 10'h001, 0, 10'h000, 0,0);
    tbl[1]  = mk("seq2",      0,1,0,0,0, 10'h000, 10'h002, 0, 10'h000, 0,0);
    tbl[2]  = mk("seq3",      0,1,0,0,0, 10'h000, 10'h003, 0, 10'h000, 0,0);
    tbl[3]  = mk("seq4",      0,1,0,0,0, 10'h000, 10'h004, 0, 10'h000, 0,0);
    tbl[4]  = mk("seq5",      0,1,0,0,0, 10'h000, 10'h005, 0, 10'h000, 0,0);
    tbl[5]  = mk("jump120",   0,1,1,0,0, 10'h120, 10'h120, 0, 10'h000, 0,0);
    tbl[6]  = mk("seq121",    0,1,0,0,0, 10'h000, 10'h121, 0, 10'h000, 0,0);
    tbl[7]  = mk("jump010",   0,1,1,0,0, 10'h010, 10'h010, 0, 10'h000, 0,0);
    tbl[8]  = mk("call200",   0,1,1,1,0, 10'h200, 10'h200, 1, 10'h011, 0,0);
    tbl[9]  = mk("seq201",    0,1,0,0,0, 10'h000, 10'h201, 1, 10'h011, 0,0);
    tbl[10] = mk("seq202",    0,1,0,0,0, 10'h000, 10'h202, 1, 10'h011, 0,0);
    tbl[11] = mk("ret011",    0,1,1,0,1, 10'h000, 10'h011, 0, 10'h000, 0,0);
    tbl[12] = mk("call_nobr", 0,1,0,1,0, 10'h3AA, 10'h012, 0, 10'h000, 0,0);
    tbl[13] = mk("ret_nobr",  0,1,0,0,1, 10'h3AA, 10'h013, 0, 10'h000, 0,0);
    tbl[14] = mk("call100",   0,1,1,1,0, 10'h100, 10'h100, 1, 10'h014, 0,0);
    tbl[15] = mk("callret",   0,1,1,1,1, 10'h3AA, 10'h014, 0, 10'h000, 0,0);
    tbl[16] = mk("call080",   0,1,1,1,0, 10'h080, 10'h080, 1, 10'h015, 0,0);
    tbl[17] = mk("ret_b2b",   0,1,1,0,1, 10'h000, 10'h015, 0, 10'h000, 0,0);

    apply(mk("reset",  1,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0,0));
    apply(mk("reset2", 1,1,1,1,0, 10'h155, 10'h000, 0, 10'h000, 0,0));
    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // nested calls until full, then one more, unwind, then one extra return
    e_pc = 10'h015;
    for (int i = 0; i < 8; i++) begin
      ret_q[i] = e_pc + 10'd1;
      e_pc     = 10'h040 + pc_t'(i * 16);
      apply(mk($sformatf("nest%0d", i), 0,1,1,1,0, e_pc, e_pc, 4'(i + 1), ret_q[i], 0,0));
    end
    apply(mk("call_full", 0,1,1,1,0, 10'h300, 10'h300, 8, ret_q[7], 1,0));
    for (int k = 0; k < 8; k++) begin
      e_pc  = ret_q[7 - k];
      e_dep = 4'(7 - k);
      apply(mk($sformatf("unwind%0d", k), 0,1,1,0,1, 10'h000, e_pc, e_dep,
               (k < 7) ? ret_q[6 - k] : 10'h000, 1,0));
    end
    apply(mk("ret_empty",  0,1,1,0,1, 10'h000, e_pc + 10'd1, 0, 10'h000, 1,1));
    apply(mk("callret_e",  0,1,1,1,1, 10'h123, e_pc + 10'd2, 0, 10'h000, 1,1));

    // wrap of pc+1 for the pushed return address and for SEQ
    apply(mk("rst_w1",  1,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0,0));
    apply(mk("jump3ff", 0,1,1,0,0, 10'h3FF, 10'h3FF, 0, 10'h000, 0,0));
    apply(mk("call_wr", 0,1,1,1,0, 10'h050, 10'h050, 1, 10'h000, 0,0));
    apply(mk("rst_w2",  1,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0,0));
    apply(mk("jump3ff", 0,1,1,0,0, 10'h3FF, 10'h3FF, 0, 10'h000, 0,0));
    apply(mk("seq_wr",  0,1,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0,0));

    // freeze with pc_en low, then reset mid-subroutine clears everything
    apply(mk("rst_h",   1,0,0,0,0, 10'h000, 10'h000, 0, 10'h000, 0,0));
    apply(mk("unf_set", 0,1,1,0,1, 10'h000, 10'h001, 0, 10'h000, 0,1));
    apply(mk("c1",      0,1,1,1,0, 10'h100, 10'h100, 1, 10'h002, 0,1));
    apply(mk("c2",      0,1,1,1,0, 10'h180, 10'h180, 2, 10'h101, 0,1));
    apply(mk("c3",      0,1,1,1,0, 10'h1C0, 10'h1C0, 3, 10'h181, 0,1));
    for (int i = 0; i < 3; i++)
      apply(mk($sformatf("hold%0d", i), 0,0,1,1,0, 10'h3AA, 10'h1C0, 3, 10'h181, 0,1));
    apply(mk("rst_mid", 1,1,1,1,0, 10'h3AA, 10'h000, 0, 10'h000, 0,0));
    apply(mk("post_rst",0,1,0,0,0, 10'h000, 10'h001, 0, 10'h000, 0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
